i2c_io_arbiter: RTL
===================

Name: i2c_io_arbiter

Overview:
- Shares one i2c_master register port (io_a/io_di/io_do/io_re/io_we) between N_REQ requesters, e.g. the APB bridge and a hardware sensor-poll engine.
- Each requester issues single-register read/write transactions with a req/ack handshake.
- Round-robin arbitration, with an optional lock so one owner can run a multi-register I2C sequence without interleaving.
- Routes i2c_irq to the current or last owner, and force-releases a stale lock after a timeout.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- AW, 6, register word-address width (matches i2c_master io_a).
- DW, 8, register data width.
- RD_LAT, 1, cycles from io_re pulse to valid io_do (1..4).
- LOCK_TO, 4096, idle cycles a locked owner may hold the port before forced release; counter width is clog2(LOCK_TO+1).

Ports:
- sys_clk  in  1  clock.
- sys_rst  in  1  synchronous reset, active-high.
- req  in  N_REQ  per-requester transaction request; held until ack.
- rnw  in  N_REQ  1 = read, 0 = write; stable while req.
- addr  in  N_REQ*AW  packed register addresses; stable while req.
- wdata  in  N_REQ*DW  packed write data; stable while req.
- lock  in  N_REQ  keep ownership after this transaction.
- ack  out  N_REQ  one-cycle completion pulse to the granted requester.
- rdata  out  DW  read data, valid in the ack cycle of a read; holds otherwise.
- owner  out  clog2(N_REQ)  current/last granted requester index.
- owned  out  1  lock currently held.
- lock_expired  out  1  one-cycle pulse on forced release.
- irq_o  out  N_REQ  i2c_irq routed to owner.
- io_a  out  AW  to i2c_master.
- io_di  out  DW  to i2c_master.
- io_we  out  1  one-cycle write strobe.
- io_re  out  1  one-cycle read strobe.
- io_do  in  DW  from i2c_master.
- i2c_irq  in  1  from i2c_master.

Behaviour:
- **Reset** (sys_rst sampled high on a clock edge; the only reset is synchronous, active-high):
  - State IDLE; rr pointer 0; owner 0; owned 0.
  - ack, io_we, io_re, lock_expired, irq_o all 0.
  - io_a and io_di 0; rdata 0; lock counter 0.
  - Reset mid-transaction aborts it with no ack and kills any strobe in that cycle. Requesters reissue.
- **States:** IDLE, OWN, ISSUE, WAIT, DONE.
- **IDLE:**
  - If any req is high, grant the first requester at or after the rr pointer (wrapping).
  - Latch addr, wdata, rnw; set owner; go to ISSUE.
  - With no req, stay in IDLE.
- **OWN** (lock held):
  - Only req[owner] is honoured; it is latched and the FSM goes to ISSUE.
  - Other requests wait; the counter is cleared on each owner request.
  - Counter increments each cycle without req[owner]. When it reaches LOCK_TO: pulse lock_expired, clear owned, set rr = owner+1 (mod N_REQ), go to IDLE.
- **ISSUE:**
  - Exactly one cycle with io_we = !rnw_l or io_re = rnw_l, and io_a/io_di driven from the latches.
  - Write goes to DONE. Read goes to WAIT.
- **WAIT:**
  - Count RD_LAT cycles, then capture io_do into rdata and go to DONE.
- **DONE:**
  - ack[owner] = 1 for this one cycle; req is ignored in DONE.
  - Lock decision uses lock[owner] sampled here:
    - lock high: owned = 1, counter cleared, go to OWN.
    - lock low: owned = 0, rr = owner+1 (mod N_REQ), go to IDLE.
  - The requester drops or changes req the cycle after ack.
- **Latency from req seen in IDLE/OWN (cycle 0):**
  - Write: io_we in cycle 1, ack in cycle 2.
  - Read: io_re in cycle 1, io_do sampled in cycle 1+RD_LAT, ack in cycle 2+RD_LAT.
- **Throughput:** back-to-back requests from one locked owner give one write per 3 cycles.
- **Simultaneous events:**
  - A requester that dropped lock is never granted twice in a row while another req is pending.
  - A LOCK_TO expiry coinciding with an owner req: the req wins (counter cleared, no expiry).
- **IRQ routing:** irq_o registered; irq_o[i] = i2c_irq & (owner == i). It follows owner after IDLE grants, and after expiry stays on the last owner until the next grant.
- **Outputs:** all outputs are registered except rdata hold; io strobes never overlap.

Decomposition:
- Shared package i2c_pkg:
  - FSM state encoding.
  - Default AW/DW.
  - i2c_master register offsets used by requesters.
- One natural sub-module: rr_pick (combinational round-robin priority select from req mask and pointer, returning a one-hot grant plus index). It is reused by the future interrupt-source arbiter.

Test Plan:
1. Single write: req[0], addr=6'h03, wdata=8'hA5, rnw=0 → io_we=1 with io_a=03, io_di=A5 in cycle 1; ack[0] in cycle 2; io_re never high.
2. Read with RD_LAT=2: req[1], rnw=1, io_do=8'h5C → io_re in cycle 1, rdata=5C with ack[1] in cycle 4, owner=1.
3. Contention: req[0] and req[1] held continuously, lock=0 → grants alternate 0,1,0,1; ack spacing 3 cycles; no starvation.
4. Lock: req0 with lock=1 for 3 writes while req1 is pending → req1 granted only after req0's final ack with lock=0; owned is high between.
5. Lock timeout with LOCK_TO=8: owner idle after locked ack → lock_expired pulse exactly 8 cycles later, owned=0, pending req1 granted next cycle.
6. Reset during WAIT of a read → no ack, io_re/io_we 0, state IDLE, rr=0; i2c_irq=1 afterward gives irq_o=01 (owner 0).

Source files
------------

// File: rtl/i2c_io_arbiter_pkg.sv
// Shared types and constants for the i2c_master register-port arbiter.
// Also carries the i2c_master register map used by requesters.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OWN,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } arb_state_t;

  localparam int I2C_AW = 6;
  localparam int I2C_DW = 8;

  localparam logic [I2C_AW-1:0] REG_PRER_LO = 6'h00;
  localparam logic [I2C_AW-1:0] REG_PRER_HI = 6'h01;
  localparam logic [I2C_AW-1:0] REG_CTR     = 6'h02;
  localparam logic [I2C_AW-1:0] REG_TXR_RXR = 6'h03;
  localparam logic [I2C_AW-1:0] REG_CR_SR   = 6'h04;

endpackage

// File: rtl/i2c_io_arbiter_if.sv
// i2c_master register port as seen by the arbiter (master) and the
// i2c_master core (slave).
import i2c_pkg::*;

interface i2c_io_arbiter_if #(
  parameter int AW = I2C_AW,
  parameter int DW = I2C_DW
);
  logic [AW-1:0] io_a;
  logic [DW-1:0] io_di;
  logic [DW-1:0] io_do;
  logic          io_we;
  logic          io_re;
  logic          i2c_irq;

  modport master (
    output io_a, io_di, io_we, io_re,
    input  io_do, i2c_irq
  );

  modport slave (
    input  io_a, io_di, io_we, io_re,
    output io_do, i2c_irq
  );
endinterface

// File: rtl/i2c_io_arbiter_rr_pick.sv
// Combinational round-robin select: first set request at or after ptr,
// wrapping, as a one-hot grant plus its index.
module rr_pick #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        idx    = IW'(j);
        gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_io_arbiter.sv
// Round-robin arbiter sharing one i2c_master register port between
// N_REQ requesters, with owner lock, lock timeout and irq routing.
import i2c_pkg::*;

module i2c_io_arbiter #(
  parameter  int N_REQ   = 2,
  parameter  int AW      = I2C_AW,
  parameter  int DW      = I2C_DW,
  parameter  int RD_LAT  = 1,
  parameter  int LOCK_TO = 4096,
  localparam int IW      = $clog2(N_REQ),
  localparam int CW      = $clog2(LOCK_TO + 1)
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    rnw,
  input  logic [N_REQ*AW-1:0] addr,
  input  logic [N_REQ*DW-1:0] wdata,
  input  logic [N_REQ-1:0]    lock,
  output logic [N_REQ-1:0]    ack,
  output logic [DW-1:0]       rdata,
  output logic [IW-1:0]       owner,
  output logic                owned,
  output logic                lock_expired,
  output logic [N_REQ-1:0]    irq_o,
  i2c_io_arbiter_if.master    io
);

  arb_state_t       state;
  logic [IW-1:0]    rr_ptr;
  logic [CW-1:0]    lock_cnt;
  logic [2:0]       wait_cnt;
  logic             rnw_l;
  logic [N_REQ-1:0] own_oh;

  logic [N_REQ-1:0] g_gnt;
  logic [IW-1:0]    g_idx;
  logic             g_any;
  logic [IW-1:0]    sel;
  logic [IW-1:0]    nxt;

  rr_pick #(.N(N_REQ)) u_pick (
    .req (req),
    .ptr (rr_ptr),
    .gnt (g_gnt),
    .idx (g_idx),
    .any (g_any)
  );

  // A locked owner only ever presents its own request
  always_comb begin
    sel = g_idx;
    if (state == ST_OWN) sel = owner;
  end

  assign nxt = (owner == IW'(N_REQ - 1)) ? '0 : owner + 1'b1;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      own_oh       <= N_REQ'(1);
      owned        <= 1'b0;
      lock_cnt     <= '0;
      wait_cnt     <= '0;
      rnw_l        <= 1'b0;
      ack          <= '0;
      rdata        <= '0;
      lock_expired <= 1'b0;
      irq_o        <= '0;
      io.io_a      <= '0;
      io.io_di     <= '0;
      io.io_we     <= 1'b0;
      io.io_re     <= 1'b0;
    end else begin
      ack          <= '0;
      io.io_we     <= 1'b0;
      io.io_re     <= 1'b0;
      lock_expired <= 1'b0;
      irq_o        <= {N_REQ{io.i2c_irq}} & own_oh;

      unique case (state)
        ST_IDLE, ST_OWN: begin
          if ((state == ST_IDLE && g_any) ||
              (state == ST_OWN && req[owner])) begin
            if (state == ST_IDLE) begin
              owner  <= g_idx;
              own_oh <= g_gnt;
            end
            lock_cnt <= '0;
            rnw_l    <= rnw[sel];
            io.io_a  <= addr[sel*AW +: AW];
            io.io_di <= wdata[sel*DW +: DW];
            io.io_we <= !rnw[sel];
            io.io_re <= rnw[sel];
            state    <= ST_ISSUE;
          end else if (state == ST_OWN) begin
            lock_cnt <= lock_cnt + 1'b1;
            if (lock_cnt == CW'(LOCK_TO - 1)) begin
              lock_expired <= 1'b1;
              owned        <= 1'b0;
              rr_ptr       <= nxt;
              state        <= ST_IDLE;
            end
          end
        end
        ST_ISSUE: begin
          wait_cnt <= '0;
          if (rnw_l) begin
            state <= ST_WAIT;
          end else begin
            ack   <= own_oh;
            state <= ST_DONE;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 3'(RD_LAT - 1)) begin
            rdata <= io.io_do;
            ack   <= own_oh;
            state <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (lock[owner]) begin
            owned    <= 1'b1;
            lock_cnt <= '0;
            state    <= ST_OWN;
          end else begin
            owned  <= 1'b0;
            rr_ptr <= nxt;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
